sm_bin2bcd: RTL and testbench

Sequential sign-magnitude to BCD converter that sits directly downstream of the sign-magnitude adder. It accepts one N-bit sign-magnitude word per conversion, converts the (N-1)-bit magnitude to D packed BCD digits with an iterative shift-and-add-3 (double-dabble) datapath, and presents digits plus sign to the seven-segment display driver. A start/ready/done_tick handshake controls each conversion.

---
 rtl/sm_bin2bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/sm_bin2bcd.sv | 101 ++++++++++
 tb/tb_sm_bin2bcd.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sm_bin2bcd_pkg.sv
// Shared types and elaboration helpers for the sign-magnitude to BCD converter.
package sm_pkg;

    // Controller states: wait for a request, run the shift-and-add-3 loop, publish.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest digit count whose range 10^d exceeds the largest (n-1)-bit magnitude.
    function automatic int min_digits(input int n);
        longint unsigned max_mag;
        longint unsigned pow10;
        int              digits;
        max_mag = (longint'(1) << (n - 1)) - 1;
        pow10   = 10;
        digits  = 1;
        while (pow10 <= max_mag) begin
            pow10  = pow10 * 10;
            digits = digits + 1;
        end
        return digits;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decade.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Add-3 correction, purely combinational.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/sm_bin2bcd.sv
// Sequential sign-magnitude to packed-BCD converter with start/ready/done_tick
// handshake. One conversion takes N cycles from acceptance to done_tick.
module sm_bin2bcd
    import sm_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [N-1:0]   sm_in,
    output logic           ready,
    output logic           done_tick,
    output logic           sign,
    output logic [4*D-1:0] bcd
);

    localparam int NW    = $clog2(N);
    localparam int MIN_D = min_digits(N);

    // Refuse to build a converter that cannot represent every magnitude.
    generate
        if (D < MIN_D) begin : g_bad_digits
            $error("sm_bin2bcd: D=%0d too small for N=%0d, need %0d", D, N, MIN_D);
        end
    endgenerate

    state_t           state_reg;
    logic [NW-1:0]    n_reg;
    logic [N-2:0]     mag_reg;
    logic [4*D-1:0]   bcd_reg;
    logic             sign_reg;
    logic [4*D-1:0]   bcd_adj;
    logic [4*D-1:0]   bcd_shift;

    // One corrector per digit, all working on the current partial result.
    generate
        for (genvar i = 0; i < D; i++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (bcd_reg[4*i +: 4]),
                .dout (bcd_adj[4*i +: 4])
            );
        end
    endgenerate

    // Corrected digits shifted left, pulling in the next magnitude bit.
    assign bcd_shift = {bcd_adj[4*D-2:0], mag_reg[N-2]};

    // Handshake outputs decode straight from the state register.
    assign ready     = (state_reg == IDLE);
    assign done_tick = (state_reg == DONE);

    // Controller, datapath and output registers.
    // NOTE: every register, including the datapath, is cleared by reset so an
    // aborted conversion leaves no stale partial value behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            mag_reg   <= '0;
            bcd_reg   <= '0;
            sign_reg  <= 1'b0;
            bcd       <= '0;
            sign      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its neighbours, as real flops do.
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mag_reg   <= sm_in[N-2:0];
                        sign_reg  <= sm_in[N-1];
                        bcd_reg   <= '0;
                        n_reg     <= NW'(N - 1);
                        state_reg <= OP;
                    end
                end
                OP: begin
                    bcd_reg <= bcd_shift;
                    mag_reg <= {mag_reg[N-3:0], 1'b0};
                    n_reg   <= n_reg - NW'(1);
                    if (n_reg == NW'(1)) begin
                        // Publish on the last shift so the result is already
                        // visible in the cycle done_tick is high.
                        bcd       <= bcd_shift;
                        sign      <= sign_reg & (|bcd_shift);
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_bin2bcd.sv
// Directed bench for sm_bin2bcd with N=8, D=3.
module tb_sm_bin2bcd;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  sm_in;
    logic        ready;
    logic        done_tick;
    logic        sign;
    logic [11:0] bcd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sm_bin2bcd #(.N(8), .D(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sm_in     (sm_in),
        .ready     (ready),
        .done_tick (done_tick),
        .sign      (sign),
        .bcd       (bcd)
    );

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference by decimal arithmetic, independent of the shift-and-add datapath.
    function automatic logic [11:0] ref_bcd(input logic [7:0] v);
        int m;
        m = int'(v[6:0]);
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    function automatic logic ref_sign(input logic [7:0] v);
        return v[7] & (v[6:0] != 7'd0);
    endfunction

    // One conversion from a ready cycle; leaves the bench in the next ready cycle.
    task automatic do_conv(input string tag, input logic [7:0] v,
                           input logic [11:0] exp_bcd, input logic exp_sign);
        int lat;
        int ready_hi;
        sm_in = v;
        start = 1'b1;
        tick(1);
        start    = 1'b0;
        sm_in    = 8'hA5;
        lat      = 1;
        ready_hi = 0;
        while (!done_tick && lat < 20) begin
            if (ready) ready_hi++;
            tick(1);
            lat++;
        end
        check({tag, "_latency"}, 16'(lat), 16'd8);
        check({tag, "_ready_low_in_op"}, 16'(ready_hi), 16'd0);
        check({tag, "_ready_at_done"}, 16'(ready), 16'd0);
        check({tag, "_bcd"}, 16'(bcd), 16'(exp_bcd));
        check({tag, "_sign"}, 16'(sign), 16'(exp_sign));
        tick(1);
        check({tag, "_ready_after"}, 16'(ready), 16'd1);
        check({tag, "_done_after"}, 16'(done_tick), 16'd0);
        check({tag, "_bcd_held"}, 16'(bcd), 16'(exp_bcd));
    endtask

    initial begin
        int         nd;
        int         d1;
        int         d2;
        int         rdy9;
        int         hold_bad;
        int         next_v;
        int         got;
        int         extra;
        int         last_done;
        int         cyc;
        int         spacing_bad;
        int         overlap;
        logic [7:0] v;
        logic [7:0] q[$];

        // Reset state
        reset_n = 1'b0;
        start   = 1'b0;
        sm_in   = 8'h00;
        #2;
        check("reset_ready", 16'(ready), 16'd1);
        check("reset_done", 16'(done_tick), 16'd0);
        check("reset_bcd", 16'(bcd), 16'h000);
        check("reset_sign", 16'(sign), 16'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);

        // Maximum magnitude, signed values, negative and positive zero
        do_conv("max_7f", 8'h7F, 12'h127, 1'b0);
        do_conv("neg_87", 8'h87, 12'h007, 1'b1);
        do_conv("neg_e4", 8'hE4, 12'h100, 1'b1);
        do_conv("negzero_80", 8'h80, 12'h000, 1'b0);
        do_conv("zero_00", 8'h00, 12'h000, 1'b0);

        // Start held during a conversion is ignored, then accepted at k+9
        sm_in = 8'h0C;
        start = 1'b1;
        tick(1);
        start    = 1'b0;
        nd       = 0;
        d1       = -1;
        d2       = -1;
        rdy9     = 0;
        hold_bad = 0;
        for (int c = 1; c <= 17; c++) begin
            if (c == 2) begin
                start = 1'b1;
                sm_in = 8'h7F;
            end
            if (c == 10) start = 1'b0;
            if (done_tick) begin
                nd++;
                if (d1 < 0) d1 = c;
                else d2 = c;
            end
            if (c == 9 && ready) rdy9 = 1;
            if (c >= 8 && c <= 16 && bcd !== 12'h012) hold_bad++;
            if (c < 17) tick(1);
        end
        check("ignore_done_count", 16'(nd), 16'd2);
        check("ignore_first_done", 16'(d1), 16'd8);
        check("ignore_second_done", 16'(d2), 16'd17);
        check("ignore_ready_k9", 16'(rdy9), 16'd1);
        check("ignore_hold_012", 16'(hold_bad), 16'd0);
        check("ignore_final_bcd", 16'(bcd), 16'h127);
        tick(1);
        check("ignore_ready_end", 16'(ready), 16'd1);

        // Reset in the middle of OP aborts the conversion
        sm_in = 8'h95;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        reset_n = 1'b0;
        #1;
        check("abort_bcd", 16'(bcd), 16'h000);
        check("abort_sign", 16'(sign), 16'd0);
        check("abort_ready", 16'(ready), 16'd1);
        check("abort_done", 16'(done_tick), 16'd0);
        nd = 0;
        for (int c = 0; c < 2; c++) begin
            tick(1);
            if (done_tick) nd++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (done_tick) nd++;
        end
        check("abort_no_done", 16'(nd), 16'd0);
        do_conv("after_abort_95", 8'h95, 12'h021, 1'b1);

        // Back-to-back sweep of every input word
        next_v      = 0;
        got         = 0;
        extra       = 0;
        last_done   = -1;
        cyc         = 0;
        spacing_bad = 0;
        overlap     = 0;
        start       = 1'b1;
        while (got < 256 && cyc < 256 * 9 + 50) begin
            if (ready && done_tick) overlap++;
            if (done_tick) begin
                if (q.size() == 0) begin
                    extra++;
                end else begin
                    v = q.pop_front();
                    check($sformatf("sweep_bcd_%02h", v), 16'(bcd), 16'(ref_bcd(v)));
                    check($sformatf("sweep_sign_%02h", v), 16'(sign), 16'(ref_sign(v)));
                end
                if (last_done >= 0 && cyc - last_done != 9) spacing_bad++;
                last_done = cyc;
                got++;
            end
            if (ready) begin
                if (next_v < 256) begin
                    sm_in = 8'(next_v);
                    q.push_back(8'(next_v));
                    next_v++;
                end else begin
                    start = 1'b0;
                end
            end
            tick(1);
            cyc++;
        end
        start = 1'b0;
        check("sweep_done_count", 16'(got), 16'd256);
        check("sweep_spurious_done", 16'(extra), 16'd0);
        check("sweep_spacing", 16'(spacing_bad), 16'd0);
        check("sweep_ready_done_overlap", 16'(overlap), 16'd0);
        check("sweep_pending", 16'(q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
